// File: rtl/writeback_stage.sv
// Final pipeline stage: registers ALU results and load returns onto the register
// file write port, diverts R15 writes to the PC, and flags forwarding hits.
module writeback_stage #(
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_regWrite,
  input  logic        ex_memToReg,
  input  logic [3:0]  ex_rd,
  input  logic [31:0] ex_aluResult,
  input  logic        mem_rdata_valid,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  input  logic [3:0]  readReg1,
  input  logic [3:0]  readReg2,
  output logic [3:0]  writeDestination,
  output logic        writeEnable,
  output logic [31:0] writeData,
  output logic        pcWrite,
  output logic [31:0] pcData,
  output logic        busy,
  output logic        loadTimeout,
  output logic        fwd1Hit,
  output logic        fwd2Hit,
  output logic [31:0] fwdData
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  localparam logic [3:0] PC_REG       = 4'd15;
  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);

  state_t      state_reg;
  logic [7:0]  count_reg;
  logic [3:0]  load_rd_reg;
  logic [3:0]  dest_reg;
  logic [31:0] data_reg;
  logic        we_reg;
  logic        pc_we_reg;
  logic [31:0] pc_data_reg;
  logic        timeout_reg;

  logic        accept;
  logic        wr_fire;
  logic [3:0]  wr_rd;
  logic [31:0] wr_value;

  assign accept = ex_valid && ex_regWrite && (state_reg == IDLE);

  // Single point deciding which result (if any) lands on the write port next cycle.
  always_comb begin
    wr_fire  = 1'b0;
    wr_rd    = 4'd0;
    wr_value = 32'd0;
    if (state_reg == IDLE) begin
      if (accept && !ex_memToReg) begin
        wr_fire  = 1'b1;
        wr_rd    = ex_rd;
        wr_value = ex_aluResult;
      end
    end else if (!flush && mem_rdata_valid) begin
      wr_fire  = 1'b1;
      wr_rd    = load_rd_reg;
      wr_value = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      count_reg   <= 8'd0;
      load_rd_reg <= 4'd0;
      dest_reg    <= 4'd0;
      data_reg    <= 32'd0;
      we_reg      <= 1'b0;
      pc_we_reg   <= 1'b0;
      pc_data_reg <= 32'd0;
      timeout_reg <= 1'b0;
    end else begin
      we_reg    <= 1'b0;
      pc_we_reg <= 1'b0;

      if (wr_fire) begin
        dest_reg <= wr_rd;
        data_reg <= wr_value;
        if (wr_rd == PC_REG) begin
          pc_we_reg   <= 1'b1;
          pc_data_reg <= wr_value;
        end else begin
          we_reg <= 1'b1;
        end
      end

      case (state_reg)
        IDLE: begin
          if (accept && ex_memToReg) begin
            load_rd_reg <= ex_rd;
            count_reg   <= 8'd0;
            state_reg   <= WAIT_LOAD;
          end
        end
        WAIT_LOAD: begin
          // flush outranks a same-edge data strobe; timeout only counts idle edges
          if (flush || mem_rdata_valid) begin
            state_reg <= IDLE;
          end else if (count_reg == TIMEOUT_LAST) begin
            state_reg   <= IDLE;
            timeout_reg <= 1'b1;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign writeDestination = dest_reg;
  assign writeEnable      = we_reg;
  assign writeData        = data_reg;
  assign pcWrite          = pc_we_reg;
  assign pcData           = pc_data_reg;
  assign busy             = (state_reg == WAIT_LOAD);
  assign loadTimeout      = timeout_reg;
  assign fwdData          = data_reg;

  logic [3:0] read_regs [2];
  logic [1:0] fwd_hits;

  assign read_regs[0] = readReg1;
  assign read_regs[1] = readReg2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign fwd_hits[gi] = we_reg && !pc_we_reg && (dest_reg == read_regs[gi]);
    end
  endgenerate

  assign fwd1Hit = fwd_hits[0];
  assign fwd2Hit = fwd_hits[1];

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU/load writes, R15 diversion, flush,
// timeout, back-to-back writes and asynchronous reset.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_regWrite;
  logic        ex_memToReg;
  logic [3:0]  ex_rd;
  logic [31:0] ex_aluResult;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        flush;
  logic [3:0]  readReg1;
  logic [3:0]  readReg2;
  logic [3:0]  writeDestination;
  logic        writeEnable;
  logic [31:0] writeData;
  logic        pcWrite;
  logic [31:0] pcData;
  logic        busy;
  logic        loadTimeout;
  logic        fwd1Hit;
  logic        fwd2Hit;
  logic [31:0] fwdData;

  int total = 0;
  int bad   = 0;

  writeback_stage #(.LOAD_TIMEOUT(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_regWrite      (ex_regWrite),
    .ex_memToReg      (ex_memToReg),
    .ex_rd            (ex_rd),
    .ex_aluResult     (ex_aluResult),
    .mem_rdata_valid  (mem_rdata_valid),
    .mem_rdata        (mem_rdata),
    .flush            (flush),
    .readReg1         (readReg1),
    .readReg2         (readReg2),
    .writeDestination (writeDestination),
    .writeEnable      (writeEnable),
    .writeData        (writeData),
    .pcWrite          (pcWrite),
    .pcData           (pcData),
    .busy             (busy),
    .loadTimeout      (loadTimeout),
    .fwd1Hit          (fwd1Hit),
    .fwd2Hit          (fwd2Hit),
    .fwdData          (fwdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic mem, input logic [3:0] rd, input logic [31:0] val);
    ex_valid     = 1'b1;
    ex_regWrite  = 1'b1;
    ex_memToReg  = mem;
    ex_rd        = rd;
    ex_aluResult = val;
    $display("txn t=%0t offer %s rd=%0d value=%h", $time, mem ? "load" : "alu", rd, val);
  endtask

  initial begin
    reset = 1'b0; ex_valid = 1'b0; ex_regWrite = 1'b0; ex_memToReg = 1'b0;
    ex_rd = 4'd0; ex_aluResult = 32'd0; mem_rdata_valid = 1'b0; mem_rdata = 32'd0;
    flush = 1'b0; readReg1 = 4'd0; readReg2 = 4'd0;

    #3;
    chk("rst_we",    32'(writeEnable), 32'd0);
    chk("rst_dest",  32'(writeDestination), 32'd0);
    chk("rst_data",  writeData, 32'd0);
    chk("rst_pcw",   32'(pcWrite), 32'd0);
    chk("rst_pcd",   pcData, 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_tmo",   32'(loadTimeout), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // ALU op to R3
    offer(1'b0, 4'd3, 32'hAAAAAAAA);
    readReg1 = 4'd3;
    tick();
    ex_valid = 1'b0;
    chk("alu_we",   32'(writeEnable), 32'd1);
    chk("alu_dest", 32'(writeDestination), 32'd3);
    chk("alu_data", writeData, 32'hAAAAAAAA);
    chk("alu_fwd1", 32'(fwd1Hit), 32'd1);
    chk("alu_fwdd", fwdData, 32'hAAAAAAAA);
    chk("alu_pcw",  32'(pcWrite), 32'd0);
    tick();
    chk("alu_we_drop", 32'(writeEnable), 32'd0);
    chk("alu_fwd1_drop", 32'(fwd1Hit), 32'd0);

    // Data strobe while idle has no effect
    mem_rdata_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_rdata_valid = 1'b0;
    chk("idle_valid_we", 32'(writeEnable), 32'd0);

    // Load to R8, data three cycles later; an ALU offer during busy is ignored
    offer(1'b1, 4'd8, 32'd0);
    tick();
    chk("ld_busy0", 32'(busy), 32'd1);
    offer(1'b0, 4'd5, 32'h55555555);
    tick();
    chk("ld_busy1", 32'(busy), 32'd1);
    chk("ld_nowr1", 32'(writeEnable), 32'd0);
    tick();
    chk("ld_busy2", 32'(busy), 32'd1);
    chk("ld_nowr2", 32'(writeEnable), 32'd0);
    ex_valid = 1'b0;
    mem_rdata_valid = 1'b1; mem_rdata = 32'hCCCCCCCC;
    tick();
    mem_rdata_valid = 1'b0;
    chk("ld_busy3", 32'(busy), 32'd0);
    chk("ld_we",    32'(writeEnable), 32'd1);
    chk("ld_dest",  32'(writeDestination), 32'd8);
    chk("ld_data",  writeData, 32'hCCCCCCCC);
    tick();
    chk("ld_we_drop", 32'(writeEnable), 32'd0);

    // ALU op to R15 goes to the PC
    offer(1'b0, 4'd15, 32'h00000040);
    readReg1 = 4'd15;
    tick();
    ex_valid = 1'b0;
    chk("pc_pcw",  32'(pcWrite), 32'd1);
    chk("pc_pcd",  pcData, 32'h00000040);
    chk("pc_we",   32'(writeEnable), 32'd0);
    chk("pc_fwd1", 32'(fwd1Hit), 32'd0);
    chk("pc_dest", 32'(writeDestination), 32'd15);
    tick();
    chk("pc_pcw_drop", 32'(pcWrite), 32'd0);

    // Load to R15 returns through the PC path
    offer(1'b1, 4'd15, 32'd0);
    tick();
    ex_valid = 1'b0;
    mem_rdata_valid = 1'b1; mem_rdata = 32'h00000080;
    tick();
    mem_rdata_valid = 1'b0;
    chk("ldpc_pcw", 32'(pcWrite), 32'd1);
    chk("ldpc_pcd", pcData, 32'h00000080);
    chk("ldpc_we",  32'(writeEnable), 32'd0);
    tick();

    // Flush wins over a same-edge data strobe
    offer(1'b1, 4'd7, 32'd0);
    tick();
    ex_valid = 1'b0;
    chk("fl_busy", 32'(busy), 32'd1);
    flush = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    flush = 1'b0; mem_rdata_valid = 1'b0;
    chk("fl_idle", 32'(busy), 32'd0);
    chk("fl_we",   32'(writeEnable), 32'd0);
    chk("fl_pcw",  32'(pcWrite), 32'd0);
    tick();
    chk("fl_we2",  32'(writeEnable), 32'd0);

    // Timeout after 16 busy cycles
    offer(1'b1, 4'd9, 32'd0);
    tick();
    ex_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      chk("tmo_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("tmo_busy15", 32'(busy), 32'd1);
    chk("tmo_flag_early", 32'(loadTimeout), 32'd0);
    tick();
    chk("tmo_idle", 32'(busy), 32'd0);
    chk("tmo_flag", 32'(loadTimeout), 32'd1);
    chk("tmo_we",   32'(writeEnable), 32'd0);
    offer(1'b0, 4'd4, 32'h00000044);
    tick();
    ex_valid = 1'b0;
    chk("tmo_alu_we",   32'(writeEnable), 32'd1);
    chk("tmo_alu_dest", 32'(writeDestination), 32'd4);
    chk("tmo_sticky",   32'(loadTimeout), 32'd1);

    // Back-to-back ALU writes to R1 then R2
    readReg1 = 4'd1; readReg2 = 4'd2;
    offer(1'b0, 4'd1, 32'h00000011);
    tick();
    chk("b2b_we1",   32'(writeEnable), 32'd1);
    chk("b2b_dest1", 32'(writeDestination), 32'd1);
    chk("b2b_data1", writeData, 32'h00000011);
    chk("b2b_f1a",   32'(fwd1Hit), 32'd1);
    chk("b2b_f2a",   32'(fwd2Hit), 32'd0);
    offer(1'b0, 4'd2, 32'h00000022);
    tick();
    ex_valid = 1'b0;
    chk("b2b_we2",   32'(writeEnable), 32'd1);
    chk("b2b_dest2", 32'(writeDestination), 32'd2);
    chk("b2b_data2", writeData, 32'h00000022);
    chk("b2b_f1b",   32'(fwd1Hit), 32'd0);
    chk("b2b_f2b",   32'(fwd2Hit), 32'd1);
    tick();
    chk("b2b_drop",  32'(writeEnable), 32'd0);

    // Non-writing instruction is consumed silently
    ex_valid = 1'b1; ex_regWrite = 1'b0; ex_memToReg = 1'b1; ex_rd = 4'd6;
    tick();
    ex_valid = 1'b0;
    chk("nrw_we",   32'(writeEnable), 32'd0);
    chk("nrw_busy", 32'(busy), 32'd0);

    // Asynchronous reset while waiting on a load
    offer(1'b1, 4'd10, 32'd0);
    tick();
    ex_valid = 1'b0;
    chk("ar_busy_pre", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_tmo",  32'(loadTimeout), 32'd0);
    chk("ar_dest", 32'(writeDestination), 32'd0);
    chk("ar_data", writeData, 32'd0);
    chk("ar_pcd",  pcData, 32'd0);
    tick();
    reset = 1'b1;
    mem_rdata_valid = 1'b1; mem_rdata = 32'hFFFF0000;
    tick();
    mem_rdata_valid = 1'b0;
    chk("ar_lost_we", 32'(writeEnable), 32'd0);
    chk("ar_lost_pc", 32'(pcWrite), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage directly upstream of the register file. It latches completed ALU results and load returns and drives the register file write port (writeDestination, writeEnable, writeData). Writes to R15 are diverted to the program counter, because the register file holds no R15. It also exposes same-cycle forwarding hits against both register file read ports.

Parameters:
LOAD_TIMEOUT, 16, max cycles in WAIT_LOAD before the load is abandoned (range 2..255).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ex_valid  in  1  instruction from execute is valid this cycle
ex_regWrite  in  1  instruction writes a register
ex_memToReg  in  1  1 = load (data from memory), 0 = ALU result
ex_rd  in  4  destination register number
ex_aluResult  in  32  ALU result
mem_rdata_valid  in  1  load data valid strobe
mem_rdata  in  32  load data
flush  in  1  discard any pending load
readReg1  in  4  register file read port 1 address (forwarding compare)
readReg2  in  4  register file read port 2 address
writeDestination  out  4  register file write address
writeEnable  out  1  register file write strobe, R0..R14 only
writeData  out  32  register file write data
pcWrite  out  1  one-cycle PC load strobe (rd = 15)
pcData  out  32  PC load value
busy  out  1  stage cannot accept; upstream holds its instruction
loadTimeout  out  1  sticky error flag, cleared only by reset
fwd1Hit / fwd2Hit  out  1 each  the writeback in flight matches readReg1 / readReg2
fwdData  out  32  equals writeData

Behaviour:
- Reset (reset=0, async): state=IDLE; counter=0; every registered output is 0 (writeDestination=0, writeEnable=0, writeData=0, pcWrite=0, pcData=0, loadTimeout=0). busy=0 in reset.
- States: IDLE, WAIT_LOAD. busy = (state==WAIT_LOAD), decoded from state only, with no combinational path from inputs.
- Accept condition: ex_valid && ex_regWrite && !busy at a posedge. ex_valid while busy=1 is ignored; upstream must hold it.
- ALU path (ex_memToReg=0), accepted at edge N:
  - From edge N to N+1, one cycle: writeEnable=1, writeDestination=ex_rd, writeData=ex_aluResult.
  - Latency 1, full throughput of 1 instruction per cycle.
- Load path (ex_memToReg=1), accepted at edge N:
  - Latch rd; go to WAIT_LOAD; clear the counter.
  - In WAIT_LOAD, a posedge with mem_rdata_valid=1 latches mem_rdata and issues the write for the following cycle. The state returns to IDLE on that same edge, so busy drops together with the write appearing.
  - mem_rdata_valid in IDLE is ignored.
- Timeout:
  - The counter increments on each WAIT_LOAD edge without valid.
  - When the counter reaches LOAD_TIMEOUT-1 without valid, the load is dropped (no write), state returns to IDLE, and loadTimeout is set to 1.
- R15 diversion: for rd=4'b1111, writeEnable stays 0. pcWrite=1 and pcData=result for one cycle at the same timing the register write would have had. writeDestination/writeData still present the value; fwd hits are suppressed.
- Write strobes are single-cycle. Outputs return to writeEnable=0/pcWrite=0 on the next edge unless a new ALU op is accepted back-to-back.
- flush:
  - In WAIT_LOAD, flush at a posedge returns the stage to IDLE with no write, even if mem_rdata_valid=1 on the same edge (flush wins).
  - flush does not cancel a write already driven on the outputs, nor an ALU op accepted on the same edge.
- Forwarding (combinational): fwd1Hit = writeEnable && (writeDestination==readReg1); fwd2Hit is the same against readReg2. Both are 0 when pcWrite=1.
- ex_regWrite=0 instructions are consumed without any output activity.
- Reset mid-WAIT_LOAD: immediate return to IDLE, the pending write is lost, busy=0.

Test Plan:
- Reset release, then an ALU op with rd=3 and 32'hAAAAAAAA → the next cycle has writeEnable=1, writeDestination=3, writeData=AAAAAAAA for exactly 1 cycle; readReg1=3 gives fwd1Hit=1.
- Load to rd=8, with mem_rdata_valid=1 and data CCCCCCCC three cycles later → busy=1 for 3 cycles. The write of CCCCCCCC to R8 occurs in the cycle after valid, with busy=0 in that cycle. An ex_valid offered during busy produces no write.
- ALU op with rd=15 and value 0x00000040 → pcWrite=1, pcData=0x40, writeEnable=0, fwd1Hit=0 with readReg1=15.
- Load followed by flush and mem_rdata_valid asserted in the same cycle → no writeEnable and no pcWrite; state is IDLE the next cycle.
- Load with no valid strobe and LOAD_TIMEOUT=16 → after 16 cycles busy=0 and loadTimeout=1 (sticky), with no write. A subsequent ALU op still writes normally.
- Back-to-back ALU ops to R1 and R2 on consecutive cycles → two consecutive single-cycle writes. Asserting reset=0 while a load is in WAIT_LOAD → all outputs 0 immediately.
